// File: rtl/is_div_n_serial.sv
// Serial divisibility checker: streams a WIDTH-bit word MSB first through a
// modulo-DIV remainder recurrence, one bit per clock, and returns the
// remainder plus a divisible flag over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// RUN   | consuming one bit of the shift register per clock
// DONE  | result presented, held until out_ready
module is_div_n_serial #(
  parameter  int WIDTH = 8,
  parameter  int DIV   = 3,
  localparam int RW    = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_rem,
  output logic             out_is_div,
  output logic             busy
);

  if (WIDTH < 2) begin : g_bad_width
    $error("is_div_n_serial: WIDTH must be 2 or more");
  end
  if (DIV < 2) begin : g_bad_div
    $error("is_div_n_serial: DIV must be 2 or more");
  end

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [RW:0] DIV_T = (RW + 1)'(DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr;
  logic [RW-1:0]    rem;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    res_rem;
  logic             res_is_div;
  logic [RW:0]      t;
  logic [RW:0]      t_red;

  // One step of the remainder recurrence; t < 2*DIV so one subtract suffices.
  always_comb begin
    t     = {rem, sr[WIDTH-1]};
    t_red = (t >= DIV_T) ? (t - DIV_T) : t;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs, decoded from state only.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift and reduce in RUN, latch the result on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      rem        <= '0;
      cnt        <= '0;
      res_rem    <= '0;
      res_is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr  <= in_data;
            rem <= '0;
            cnt <= CW'(WIDTH);
          end
        end
        RUN: begin
          rem <= t_red[RW-1:0];
          sr  <= {sr[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_rem    <= t_red[RW-1:0];
            res_is_div <= (t_red == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers hold the last answer through IDLE and the next RUN.
  assign out_rem    = res_rem;
  assign out_is_div = res_is_div;

endmodule

// File: tb/tb_is_div_n_serial.sv
// Directed bench for is_div_n_serial across several WIDTH/DIV instances.
module tb_is_div_n_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance index: 0:W8/D3 1:W16/D7 2:W8/D2 3:W8/D5 4:W8/D10
  logic [4:0]  ivalid = '0;
  logic [4:0]  ordy = '1;
  logic [15:0] idata [5];
  logic [4:0]  iready, ovalid, oisdiv, obusy;
  logic [1:0]  rem0;
  logic [2:0]  rem1;
  logic [0:0]  rem2;
  logic [2:0]  rem3;
  logic [3:0]  rem4;
  logic [3:0]  remv [5];

  int checks = 0;
  int failures = 0;
  int wid [5] = '{8, 16, 8, 8, 8};
  int dv  [5] = '{3, 7, 2, 5, 10};

  initial for (int i = 0; i < 5; i++) idata[i] = '0;

  always_comb begin
    remv[0] = {2'b0, rem0};
    remv[1] = {1'b0, rem1};
    remv[2] = {3'b0, rem2};
    remv[3] = {1'b0, rem3};
    remv[4] = rem4;
  end

  is_div_n_serial #(.WIDTH(8), .DIV(3)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivalid[0]), .in_ready(iready[0]),
    .in_data(idata[0][7:0]), .out_valid(ovalid[0]), .out_ready(ordy[0]),
    .out_rem(rem0), .out_is_div(oisdiv[0]), .busy(obusy[0]));
  is_div_n_serial #(.WIDTH(16), .DIV(7)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivalid[1]), .in_ready(iready[1]),
    .in_data(idata[1]), .out_valid(ovalid[1]), .out_ready(ordy[1]),
    .out_rem(rem1), .out_is_div(oisdiv[1]), .busy(obusy[1]));
  is_div_n_serial #(.WIDTH(8), .DIV(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivalid[2]), .in_ready(iready[2]),
    .in_data(idata[2][7:0]), .out_valid(ovalid[2]), .out_ready(ordy[2]),
    .out_rem(rem2), .out_is_div(oisdiv[2]), .busy(obusy[2]));
  is_div_n_serial #(.WIDTH(8), .DIV(5)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivalid[3]), .in_ready(iready[3]),
    .in_data(idata[3][7:0]), .out_valid(ovalid[3]), .out_ready(ordy[3]),
    .out_rem(rem3), .out_is_div(oisdiv[3]), .busy(obusy[3]));
  is_div_n_serial #(.WIDTH(8), .DIV(10)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivalid[4]), .in_ready(iready[4]),
    .in_data(idata[4][7:0]), .out_valid(ovalid[4]), .out_ready(ordy[4]),
    .out_rem(rem4), .out_is_div(oisdiv[4]), .busy(obusy[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Send one word to instance k and check latency and result.
  // stall: keep in_valid high with changing data during RUN.
  // bp: hold out_ready low for 20 cycles after out_valid rises.
  task automatic transact(input int k, input logic [15:0] d, input int exp_rem,
                          input bit stall, input bit bp, input string tag);
    int cyc;
    logic [3:0] held;
    cyc = 0;
    @(negedge clk);
    while (!iready[k] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " in_ready_before_accept"}, 32'(iready[k]), 1);
    if (bp) ordy[k] = 1'b0;
    ivalid[k] = 1'b1;
    idata[k]  = d;
    @(posedge clk);
    @(negedge clk);
    if (stall) idata[k] = 16'($urandom);
    else       ivalid[k] = 1'b0;
    cyc = 0;
    while (!ovalid[k] && cyc < 100) begin
      if (stall) begin
        chk({tag, " in_ready_low_in_run"}, 32'(iready[k]), 0);
        idata[k] = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    ivalid[k] = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'(wid[k]));
    chk({tag, " rem"}, 32'(remv[k]), 32'(exp_rem));
    chk({tag, " is_div"}, 32'(oisdiv[k]), 32'(exp_rem == 0));
    if (bp) begin
      held = remv[k];
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk({tag, " bp_out_valid"}, 32'(ovalid[k]), 1);
        chk({tag, " bp_rem_stable"}, 32'(remv[k]), 32'(held));
        chk({tag, " bp_in_ready"}, 32'(iready[k]), 0);
      end
      ordy[k] = 1'b1;
      @(negedge clk);
      chk({tag, " bp_release_in_ready"}, 32'(iready[k]), 1);
      chk({tag, " bp_release_out_valid"}, 32'(ovalid[k]), 0);
    end
  endtask

  logic [7:0] seq_d [7] = '{8'hFF, 8'h52, 8'h40, 8'h1F, 8'h00, 8'h8C, 8'hFC};
  int         seq_r [7] = '{0, 1, 1, 1, 0, 2, 0};

  initial begin
    int seen;
    int ks [4] = '{2, 0, 3, 4};
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(iready[0]), 1);
    chk("reset out_valid", 32'(ovalid[0]), 0);
    chk("reset busy", 32'(obusy[0]), 0);
    chk("reset rem", 32'(remv[0]), 0);
    chk("reset is_div", 32'(oisdiv[0]), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      transact(0, {8'h00, seq_d[i]}, seq_r[i], 1'b0, 1'b0, $sformatf("w8d3_%0d", i));

    transact(1, 16'hFFFF, 1, 1'b0, 1'b0, "w16d7_ffff");
    transact(1, 16'h3F01, 1, 1'b0, 1'b0, "w16d7_3f01");
    transact(1, 16'h3F00, 0, 1'b0, 1'b0, "w16d7_3f00");

    transact(0, 16'h0052, 1, 1'b0, 1'b1, "backpressure");
    transact(0, 16'h008C, 2, 1'b1, 1'b0, "stall");

    // Reset three edges into RUN, between clock edges.
    @(negedge clk);
    ivalid[0] = 1'b1;
    idata[0]  = 16'h00FF;
    @(posedge clk);
    #1 ivalid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst in_ready", 32'(iready[0]), 1);
    chk("async_rst out_valid", 32'(ovalid[0]), 0);
    chk("async_rst busy", 32'(obusy[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ovalid[0]) seen++;
    end
    chk("async_rst no_result", 32'(seen), 0);
    transact(0, 16'h0040, 1, 1'b0, 1'b0, "after_rst");

    for (int j = 0; j < 4; j++)
      for (int v = 0; v < 256; v++)
        transact(ks[j], 16'(v), v % dv[ks[j]], 1'b0, 1'b0,
                 $sformatf("exh_d%0d_%0d", dv[ks[j]], v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/is_div_n_serial.md
Name: is_div_n_serial

Overview:
- Streaming, parametrised successor to the combinational divide-by-3 checker.
- Accepts WIDTH-bit unsigned words over a valid/ready input handshake.
- Runs a one-bit-per-clock remainder state machine, MSB first, modulo DIV.
- Returns the remainder and a divisible flag over a valid/ready output handshake. Sits between a word source and downstream control logic that needs divisibility tests for arbitrary divisors and widths.

Parameters:
- WIDTH, 8, input word width in bits; legal range 2 or more.
- DIV, 3, divisor; legal range 2 or more. Elaboration error otherwise.
- RW, $clog2(DIV), derived localparam, not overridable; width of the remainder output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  unsigned word to test.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_rem  output  RW  in_data mod DIV.
- out_is_div  output  1  1 when out_rem == 0.
- busy  output  1  1 in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, out_rem=0, out_is_div=0, busy=0.
  - The shift register, remainder and bit counter clear to 0.
  - An in-flight word is discarded; no result is produced for it.
- State machine:
  - IDLE: in_ready=1. On a rising edge with in_valid=1, capture in_data into the shift register, set rem=0 and cnt=WIDTH, and move to RUN.
  - RUN: in_ready=0, busy=1. Each edge:
    - rem <= (2*rem + sr[WIDTH-1]) mod DIV.
    - sr shifts left by 1 with 0 fill.
    - cnt decrements.
    - The edge that consumes the last bit (cnt==1) moves to DONE.
  - DONE: out_valid=1 and out_rem=rem. out_is_div is 1 exactly when rem==0. On an edge with out_ready=1, move to IDLE.
- Arithmetic:
  - t = 2*rem + bit is computed in RW+1 bits.
  - Because t < 2*DIV, the reduction is a single conditional subtract: if t >= DIV then t - DIV, else t. No divider is inferred.
- Timing and latency:
  - If the word is accepted on edge E0, out_valid rises after edge E(WIDTH). Latency is WIDTH cycles from acceptance to result valid.
  - Minimum issue interval is WIDTH+2 cycles with out_ready held at 1: accept, WIDTH RUN edges, 1 DONE edge.
- Handshake rules:
  - No overlap: in_ready is 0 throughout RUN and DONE.
  - in_ready depends only on state, never on in_valid.
  - out_rem and out_is_div are held stable while out_valid=1 and out_ready=0; backpressure is unbounded.
  - out_ready asserted outside DONE is ignored.
  - The DONE to IDLE edge does not accept a new word. in_ready rises in the following cycle.
  - In IDLE, out_rem and out_is_div hold the last result, but are meaningful only when out_valid=1.
- Boundary cases:
  - in_data=0 gives rem=0 and is_div=1.
  - in_data=2^WIDTH-1 requires no overflow: the remainder register never exceeds DIV-1.
  - in_data changing while in_ready=0 has no effect.
  - When DIV is a power of 2, the result equals the low log2(DIV) bits of in_data.

Test Plan:
- WIDTH=8, DIV=3, out_ready=1; send in sequence 0xFF, 0x52, 0x40, 0x1F, 0x00, 0x8C, 0xFC -> out_rem = 0,1,1,1,0,2,0 and out_is_div = 1,0,0,0,1,0,1. out_valid rises exactly 8 cycles after each acceptance.
- WIDTH=16, DIV=7: send 0xFFFF -> out_rem=1, out_is_div=0. Send 0x3F01 (16129 = 7*2304+1) -> out_rem=1. Send 0x3F00 -> out_rem=0, out_is_div=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid rises -> out_valid and out_rem stay constant, and in_ready=0 throughout. Raising out_ready for 1 cycle returns to IDLE, with in_ready=1 on the next cycle.
- Input stall: keep in_valid=1 with data that changes every cycle during RUN -> the result reflects only the word captured on the accept edge.
- Reset mid-operation: assert rst_n=0 asynchronously 3 cycles into RUN (between edges) -> in_ready=1 and out_valid=0 immediately. No result emerges after release, and the next word is processed correctly.
- Exhaustive check at WIDTH=8 with DIV in {2,3,5,10}: all 256 inputs, compared against a reference model (in_data % DIV) -> zero mismatches.
